// File: rtl/residual_row_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : residual_row_pipe
//  Purpose  : Per-lane signed/absolute residuals for one row per beat, held in
//             a 2-entry elastic buffer, with row tagging and a per-block SAD.
//  Revision : 1.0  initial release
// ============================================================================
module residual_row_pipe #(
    parameter  int LANES     = 8,
    parameter  int BIT_DEPTH = 8,
    parameter  int ROWS      = 8,
    localparam int c_rw      = (ROWS > 2) ? $clog2(ROWS) : 1,
    localparam int c_sw      = BIT_DEPTH + $clog2(LANES * ROWS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LANES*BIT_DEPTH-1:0]       org,
    input  logic [LANES*BIT_DEPTH-1:0]       cur,
    input  logic                             mode,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANES*(BIT_DEPTH+1)-1:0]   diff,
    output logic [c_rw-1:0]                  out_row,
    output logic                             out_last,
    output logic                             sad_valid,
    output logic [c_sw-1:0]                  sad
);

    localparam int              c_dw       = LANES * (BIT_DEPTH + 1);
    localparam int              c_pad      = c_sw - BIT_DEPTH;
    localparam logic [c_rw-1:0] c_last_row = c_rw'(ROWS - 1);

    logic [c_dw-1:0]      w_in_diff;
    logic [BIT_DEPTH-1:0] w_lane_abs [LANES];
    logic [c_sw-1:0]      w_in_sum;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [BIT_DEPTH:0] w_d;
        logic [BIT_DEPTH:0] w_neg;
        // Zero-extending both operands keeps the difference exact in one extra bit.
        assign w_d   = {1'b0, org[gi*BIT_DEPTH +: BIT_DEPTH]} - {1'b0, cur[gi*BIT_DEPTH +: BIT_DEPTH]};
        assign w_neg = -w_d;
        assign w_lane_abs[gi] = w_d[BIT_DEPTH] ? w_neg[BIT_DEPTH-1:0] : w_d[BIT_DEPTH-1:0];
        assign w_in_diff[gi*(BIT_DEPTH+1) +: BIT_DEPTH+1] = mode ? {1'b0, w_lane_abs[gi]} : w_d;
    end

    always_comb begin
        w_in_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_in_sum = w_in_sum + {{c_pad{1'b0}}, w_lane_abs[i]};
        end
    end

    logic            r_out_valid_q, w_out_valid_d;
    logic [c_dw-1:0] r_out_diff_q,  w_out_diff_d;
    logic [c_rw-1:0] r_out_row_q,   w_out_row_d;
    logic [c_sw-1:0] r_out_sum_q,   w_out_sum_d;
    logic            r_skid_valid_q, w_skid_valid_d;
    logic [c_dw-1:0] r_skid_diff_q,  w_skid_diff_d;
    logic [c_rw-1:0] r_skid_row_q,   w_skid_row_d;
    logic [c_sw-1:0] r_skid_sum_q,   w_skid_sum_d;
    logic [c_rw-1:0] r_in_row_q,    w_in_row_d;
    logic [c_sw-1:0] r_acc_q,       w_acc_d;
    logic [c_sw-1:0] r_sad_q,       w_sad_d;
    logic            r_sad_valid_q, w_sad_valid_d;

    logic w_in_fire;
    logic w_out_fire;
    logic w_out_last;

    assign w_in_fire  = in_valid && !r_skid_valid_q;
    assign w_out_fire = r_out_valid_q && out_ready;
    assign w_out_last = (r_out_row_q == c_last_row);

    always_comb begin
        w_out_valid_d  = r_out_valid_q;
        w_out_diff_d   = r_out_diff_q;
        w_out_row_d    = r_out_row_q;
        w_out_sum_d    = r_out_sum_q;
        w_skid_valid_d = r_skid_valid_q;
        w_skid_diff_d  = r_skid_diff_q;
        w_skid_row_d   = r_skid_row_q;
        w_skid_sum_d   = r_skid_sum_q;
        w_in_row_d     = r_in_row_q;
        w_acc_d        = r_acc_q;
        w_sad_d        = r_sad_q;
        w_sad_valid_d  = 1'b0;

        if (w_in_fire) begin
            w_in_row_d = (r_in_row_q == c_last_row) ? '0 : r_in_row_q + c_rw'(1);
        end

        // The skid can only hold data while the output register is full, so it
        // always has priority over a new beat when the output slot frees up.
        if (!r_out_valid_q || w_out_fire) begin
            if (r_skid_valid_q) begin
                w_out_valid_d  = 1'b1;
                w_out_diff_d   = r_skid_diff_q;
                w_out_row_d    = r_skid_row_q;
                w_out_sum_d    = r_skid_sum_q;
                w_skid_valid_d = 1'b0;
            end else if (w_in_fire) begin
                w_out_valid_d  = 1'b1;
                w_out_diff_d   = w_in_diff;
                w_out_row_d    = r_in_row_q;
                w_out_sum_d    = w_in_sum;
            end else begin
                w_out_valid_d  = 1'b0;
            end
        end else if (w_in_fire) begin
            w_skid_valid_d = 1'b1;
            w_skid_diff_d  = w_in_diff;
            w_skid_row_d   = r_in_row_q;
            w_skid_sum_d   = w_in_sum;
        end

        if (w_out_fire) begin
            if (w_out_last) begin
                w_sad_d       = r_acc_q + r_out_sum_q;
                w_sad_valid_d = 1'b1;
                w_acc_d       = '0;
            end else begin
                w_acc_d       = r_acc_q + r_out_sum_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid_q  <= 1'b0;
            r_out_diff_q   <= '0;
            r_out_row_q    <= '0;
            r_out_sum_q    <= '0;
            r_skid_valid_q <= 1'b0;
            r_skid_diff_q  <= '0;
            r_skid_row_q   <= '0;
            r_skid_sum_q   <= '0;
            r_in_row_q     <= '0;
            r_acc_q        <= '0;
            r_sad_q        <= '0;
            r_sad_valid_q  <= 1'b0;
        end else begin
            r_out_valid_q  <= w_out_valid_d;
            r_out_diff_q   <= w_out_diff_d;
            r_out_row_q    <= w_out_row_d;
            r_out_sum_q    <= w_out_sum_d;
            r_skid_valid_q <= w_skid_valid_d;
            r_skid_diff_q  <= w_skid_diff_d;
            r_skid_row_q   <= w_skid_row_d;
            r_skid_sum_q   <= w_skid_sum_d;
            r_in_row_q     <= w_in_row_d;
            r_acc_q        <= w_acc_d;
            r_sad_q        <= w_sad_d;
            r_sad_valid_q  <= w_sad_valid_d;
        end
    end

    assign in_ready  = !r_skid_valid_q;
    assign out_valid = r_out_valid_q;
    assign diff      = r_out_diff_q;
    assign out_row   = r_out_row_q;
    assign out_last  = w_out_last;
    assign sad_valid = r_sad_valid_q;
    assign sad       = r_sad_q;

endmodule
`default_nettype wire

// File: tb/tb_residual_row_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_residual_row_pipe
//  Purpose  : Directed self-checking bench for residual_row_pipe (8x8x8 config).
//  Revision : 1.0  initial release
// ============================================================================
module tb_residual_row_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] org;
    logic [63:0] cur;
    logic        mode;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] diff;
    logic [2:0]  out_row;
    logic        out_last;
    logic        sad_valid;
    logic [13:0] sad;

    int n_checks = 0;
    int n_fail   = 0;

    residual_row_pipe #(.LANES(8), .BIT_DEPTH(8), .ROWS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .org       (org),
        .cur       (cur),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .out_row   (out_row),
        .out_last  (out_last),
        .sad_valid (sad_valid),
        .sad       (sad)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        rst_n    = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        org       = {8{8'd200}};
        cur       = {8{8'd1}};
        mode      = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        n_checks++;
        if ({in_ready, out_valid, out_row, out_last, sad_valid} !== 7'b1_0_000_0_0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy=%b ov=%b row=%0d last=%b sv=%b required 1 0 0 0 0",
                     in_ready, out_valid, out_row, out_last, sad_valid);
        end
        n_checks++;
        if (diff !== 72'h0) begin
            n_fail++;
            $display("FAIL reset_diff: got %h required 0", diff);
        end
        n_checks++;
        if (sad !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_sad: got %0d required 0", sad);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
    endtask

    task automatic test_signed_diff();
        do_reset();
        out_ready = 1'b1;
        mode      = 1'b0;
        org       = {8{8'd0}};
        cur       = {8{8'd255}};
        in_valid  = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL signed_in_ready: got %b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_row, out_last} !== 5'b1_000_0) begin
            n_fail++;
            $display("FAIL signed_ctrl: got ov=%b row=%0d last=%b required 1 0 0", out_valid, out_row, out_last);
        end
        n_checks++;
        if (diff !== {8{9'h101}}) begin
            n_fail++;
            $display("FAIL signed_diff: got %h required %h", diff, {8{9'h101}});
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL signed_drain: got ov=%b required 0", out_valid);
        end
    endtask

    task automatic test_abs_diff();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        mode      = 1'b1;
        org       = {8{8'd0}};
        cur       = {8{8'd255}};
        step();
        n_checks++;
        if (diff !== {8{9'h0FF}}) begin
            n_fail++;
            $display("FAIL abs_neg255: got %h required %h", diff, {8{9'h0FF}});
        end
        mode = 1'b0;
        org  = {8{8'd200}};
        cur  = {8{8'd56}};
        step();
        n_checks++;
        if (diff !== {8{9'h090}}) begin
            n_fail++;
            $display("FAIL signed_144: got %h required %h", diff, {8{9'h090}});
        end
        mode = 1'b1;
        step();
        n_checks++;
        if (diff !== {8{9'h090}}) begin
            n_fail++;
            $display("FAIL abs_144: got %h required %h", diff, {8{9'h090}});
        end
        // lane 0: 5-9 = -4, lane 7: 9-5 = +4, middle lanes zero
        mode = 1'b0;
        org  = {8'd9, 48'h0, 8'd5};
        cur  = {8'd5, 48'h0, 8'd9};
        step();
        n_checks++;
        if (diff !== {9'h004, 54'h0, 9'h1FC}) begin
            n_fail++;
            $display("FAIL signed_mixed: got %h required %h", diff, {9'h004, 54'h0, 9'h1FC});
        end
        n_checks++;
        if (out_row !== 3'd3) begin
            n_fail++;
            $display("FAIL abs_row_tag: got %0d required 3", out_row);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_stream_sad();
        do_reset();
        out_ready = 1'b1;
        mode      = 1'b0;
        org       = {8{8'd10}};
        cur       = {8{8'd7}};
        in_valid  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            n_checks++;
            if ({in_ready, out_valid, out_row, out_last} !== {1'b1, 1'b1, 3'(k % 8), (k % 8) == 7}) begin
                n_fail++;
                $display("FAIL stream_beat%0d: got rdy=%b ov=%b row=%0d last=%b required 1 1 %0d %b",
                         k, in_ready, out_valid, out_row, out_last, k % 8, (k % 8) == 7);
            end
            n_checks++;
            if (sad_valid !== (k == 8)) begin
                n_fail++;
                $display("FAIL stream_sad_valid%0d: got %b required %b", k, sad_valid, k == 8);
            end
            if (k == 8) begin
                n_checks++;
                if (sad !== 14'd192) begin
                    n_fail++;
                    $display("FAIL stream_sad_blk1: got %0d required 192", sad);
                end
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if ({sad_valid, sad} !== {1'b1, 14'd192}) begin
            n_fail++;
            $display("FAIL stream_sad_blk2: got sv=%b sad=%0d required 1 192", sad_valid, sad);
        end
        step();
        n_checks++;
        if ({sad_valid, sad, out_valid} !== {1'b0, 14'd192, 1'b0}) begin
            n_fail++;
            $display("FAIL stream_sad_hold: got sv=%b sad=%0d ov=%b required 0 192 0", sad_valid, sad, out_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        mode      = 1'b0;
        cur       = {8{8'd0}};
        in_valid  = 1'b1;
        org       = {8{8'd1}};
        step();
        n_checks++;
        if ({in_ready, out_valid} !== 2'b11) begin
            n_fail++;
            $display("FAIL bp_first: got rdy=%b ov=%b required 1 1", in_ready, out_valid);
        end
        org = {8{8'd2}};
        step();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_skid_full: got rdy=%b required 0", in_ready);
        end
        org = {8{8'd3}};
        for (int s = 0; s < 2; s++) begin
            step();
            n_checks++;
            if ({in_ready, out_valid, out_row, diff} !== {1'b0, 1'b1, 3'd0, {8{9'h001}}}) begin
                n_fail++;
                $display("FAIL bp_stall%0d: got rdy=%b ov=%b row=%0d diff=%h required 0 1 0 %h",
                         s, in_ready, out_valid, out_row, diff, {8{9'h001}});
            end
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if ({in_ready, out_valid, out_row, diff} !== {1'b1, 1'b1, 3'd1, {8{9'h002}}}) begin
            n_fail++;
            $display("FAIL bp_drain_b: got rdy=%b ov=%b row=%0d diff=%h required 1 1 1 %h",
                     in_ready, out_valid, out_row, diff, {8{9'h002}});
        end
        step();
        n_checks++;
        if ({out_valid, out_row, diff} !== {1'b1, 3'd2, {8{9'h003}}}) begin
            n_fail++;
            $display("FAIL bp_drain_c: got ov=%b row=%0d diff=%h required 1 2 %h", out_valid, out_row, diff, {8{9'h003}});
        end
        org = {8{8'd4}};
        step();
        n_checks++;
        if ({out_valid, out_row, diff} !== {1'b1, 3'd3, {8{9'h004}}}) begin
            n_fail++;
            $display("FAIL bp_drain_d: got ov=%b row=%0d diff=%h required 1 3 %h", out_valid, out_row, diff, {8{9'h004}});
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_empty: got ov=%b rdy=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_max_sad();
        do_reset();
        out_ready = 1'b1;
        mode      = 1'b1;
        org       = {8{8'd255}};
        cur       = {8{8'd0}};
        in_valid  = 1'b1;
        for (int k = 0; k < 8; k++) step();
        in_valid = 1'b0;
        step();
        n_checks++;
        if ({sad_valid, sad} !== {1'b1, 14'd16320}) begin
            n_fail++;
            $display("FAIL max_sad: got sv=%b sad=%0d required 1 16320", sad_valid, sad);
        end
    endtask

    task automatic test_reset_mid_block();
        do_reset();
        out_ready = 1'b1;
        mode      = 1'b0;
        org       = {8{8'd10}};
        cur       = {8{8'd7}};
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) step();
        n_checks++;
        if (out_row !== 3'd3) begin
            n_fail++;
            $display("FAIL mid_pre_row: got %0d required 3", out_row);
        end
        rst_n = 1'b0;
        step();
        n_checks++;
        if ({in_ready, out_valid, out_row, out_last, sad_valid, sad, diff} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 14'd0, 72'h0}) begin
            n_fail++;
            $display("FAIL mid_reset_state: got rdy=%b ov=%b row=%0d last=%b sv=%b sad=%0d diff=%h required 1 0 0 0 0 0 0",
                     in_ready, out_valid, out_row, out_last, sad_valid, sad, diff);
        end
        rst_n = 1'b1;
        org   = {8{8'd5}};
        cur   = {8{8'd1}};
        for (int k = 0; k < 8; k++) begin
            step();
            n_checks++;
            if ({out_valid, out_row, sad_valid} !== {1'b1, 3'(k), 1'b0}) begin
                n_fail++;
                $display("FAIL mid_post_beat%0d: got ov=%b row=%0d sv=%b required 1 %0d 0",
                         k, out_valid, out_row, sad_valid, k);
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if ({sad_valid, sad} !== {1'b1, 14'd256}) begin
            n_fail++;
            $display("FAIL mid_post_sad: got sv=%b sad=%0d required 1 256", sad_valid, sad);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        org       = '0;
        cur       = '0;
        mode      = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_signed_diff();
        test_abs_diff();
        test_stream_sad();
        test_backpressure();
        test_max_sad();
        test_reset_mid_block();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
